// File: rtl/bcd_display_converter.sv
// bcd_display_converter: sequential double-dabble binary-to-BCD converter with saturation at 10^DIGITS-1.
module bcd_display_converter #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [4*DIGITS-1:0]   val_out,
  output logic                  valid_out,
  output logic                  overflow_out
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = (WIDTH > 34) ? WIDTH : 34;
  function automatic logic [LW-1:0] max_val();
    logic [LW-1:0] p;
    p = LW'(1);
    for (int i = 0; i < DIGITS; i++) p = p * LW'(10);
    return p - LW'(1);
  endfunction
  localparam logic [LW-1:0] MAX_VAL = max_val();
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [BW-1:0]    w_adj;
  // every digit is corrected in parallel before the shift
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k+:4] = (r_bcd[4*k+:4] >= 4'd5) ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
  end
  assign ready_out = (r_state == IDLE);
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      val_out      <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        IDLE: if (valid_in) begin
          r_bin   <= bin_in;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_ovf   <= LW'(bin_in) > MAX_VAL;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_bcd   <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(WIDTH - 1)) ? LATCH : SHIFT;
        end
        LATCH: begin
          val_out      <= r_ovf ? {DIGITS{4'h9}} : r_bcd;
          overflow_out <= r_ovf;
          valid_out    <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_display_converter.sv
// tb_bcd_display_converter: directed and random checks of the BCD converter against an arithmetic model.
module tb_bcd_display_converter;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [26:0] bin_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] val_out;
  logic        valid_out;
  logic        overflow_out;
  int          checks = 0;
  int          errors = 0;

  bcd_display_converter dut (
    .clk_in(clk_in), .rst_in(rst_in), .bin_in(bin_in), .valid_in(valid_in),
    .ready_out(ready_out), .val_out(val_out), .valid_out(valid_out), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // decimal digits by repeated division; anything past eight digits saturates
  task automatic model(input int unsigned v, output logic [31:0] bcd, output logic ovf);
    int unsigned x;
    ovf = (v > 99999999);
    bcd = 32'h9999_9999;
    if (!ovf) begin
      x = v;
      for (int d = 0; d < 8; d++) begin
        bcd[4*d+:4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endtask

  task automatic convert(input int unsigned v, input bit noise);
    logic [31:0] exp_v, prev;
    logic        exp_o, prev_o;
    prev   = val_out;
    prev_o = overflow_out;
    model(v, exp_v, exp_o);
    chk("ready_before_accept", 32'(ready_out), 32'd1);
    bin_in   = 27'(v);
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    bin_in   = 27'($urandom);
    chk("ready_low_e0", 32'(ready_out), 32'd0);
    for (int n = 1; n <= 28; n++) begin
      if (noise && (n == 5 || n == 20)) begin
        valid_in = 1'b1;
        bin_in   = 27'd7;
      end
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      if (n < 28) begin
        chk("valid_early", 32'(valid_out), 32'd0);
        chk("ready_busy", 32'(ready_out), 32'd0);
        chk("val_hold", val_out, prev);
        chk("ovf_hold", 32'(overflow_out), 32'(prev_o));
      end else begin
        chk("valid_pulse", 32'(valid_out), 32'd1);
        chk("ready_back", 32'(ready_out), 32'd1);
        chk("val_result", val_out, exp_v);
        chk("ovf_result", 32'(overflow_out), 32'(exp_o));
      end
    end
    @(posedge clk_in); #1;
    chk("valid_single", 32'(valid_out), 32'd0);
    chk("val_stable", val_out, exp_v);
  endtask

  initial begin
    logic [31:0] exp_v;
    logic        exp_o;
    int          acc[$];
    int          cyc, nres;
    bit          pre_ready, stray;
    #2;
    chk("rst_val", val_out, 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    convert(0, 0);
    convert(12345678, 0);
    convert(99999999, 0);
    convert(100000000, 0);
    convert(134217727, 0);
    convert(42, 1);
    // abort a conversion with an asynchronous reset in the middle of a cycle
    bin_in   = 27'd555;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #4 rst_in = 1'b0;
    #1;
    chk("abort_val", val_out, 32'd0);
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_ovf", 32'(overflow_out), 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    stray = 1'b0;
    repeat (35) begin
      @(posedge clk_in); #1;
      if (valid_out) stray = 1'b1;
    end
    chk("abort_no_valid", 32'(stray), 32'd0);
    chk("abort_ready", 32'(ready_out), 32'd1);
    convert(9, 0);
    // held valid_in: accepts should land every 29 cycles
    cyc = 0; nres = 0;
    bin_in   = 27'd1;
    valid_in = 1'b1;
    while (nres < 3 && cyc < 200) begin
      pre_ready = ready_out;
      @(posedge clk_in); #1;
      cyc++;
      if (pre_ready && valid_in) begin
        acc.push_back(cyc);
        if (acc.size() == 3) valid_in = 1'b0;
        bin_in = bin_in + 27'd1;
      end
      if (valid_out) begin
        nres++;
        model(nres, exp_v, exp_o);
        chk("stream_val", val_out, exp_v);
        chk("stream_ovf", 32'(overflow_out), 32'(exp_o));
      end
    end
    valid_in = 1'b0;
    chk("stream_results", 32'(nres), 32'd3);
    chk("stream_accepts", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("stream_gap1", 32'(acc[1] - acc[0]), 32'd29);
      chk("stream_gap2", 32'(acc[2] - acc[1]), 32'd29);
    end
    for (int i = 0; i < 10; i++) begin
      int unsigned r;
      r = (i % 3 == 0) ? $urandom_range(134217727, 90000000) : $urandom_range(99999999, 0);
      convert(r, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_display_converter.md
# bcd_display_converter

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) feeding the 8-digit seven-segment display controller. It accepts an unsigned binary value through a valid/ready handshake and converts it over WIDTH cycles. It then presents a packed 8-digit BCD word on `val_out`, which drives the controller's 32-bit `val_in` directly. Inputs above the displayable range saturate to all nines and raise an overflow flag.

## Interface
- `WIDTH`, default 27: binary input width; 27 bits covers 0..134,217,727.
- `DIGITS`, default 8: BCD digits produced. `val_out` width is 4*DIGITS (32 at default). The saturation limit is 10^DIGITS − 1.
- `clk_in`  input  1: system clock; all state changes on its rising edge.
- `rst_in`  input  1: reset, asynchronous assert, active-low. 0 = in reset.
- `bin_in`  input  WIDTH: unsigned binary value to convert; sampled only on an accepted transfer.
- `valid_in`  input  1: `bin_in` is valid this cycle.
- `ready_out`  output  1: block can accept; equals (state == IDLE).
- `val_out`  output  4*DIGITS: last completed BCD result, registered. Digit k occupies [4k+3:4k], and digit 0 is the least-significant decimal digit.
- `valid_out`  output  1: one-cycle pulse, high in the cycle in which `val_out` first shows a new result.
- `overflow_out`  output  1: registered; 1 if the result currently on `val_out` was saturated.

## Operation
- States: IDLE, SHIFT, LATCH.
- **IDLE:** `ready_out` = 1. On the edge where `valid_in` && `ready_out` (accept):
  - load the binary shift register with `bin_in`;
  - clear the BCD scratch register (4*DIGITS bits);
  - clear the iteration counter;
  - register `ovf` = (`bin_in` > 10^DIGITS − 1);
  - go to SHIFT.
- **SHIFT:** one iteration per clock. The new {scratch, binary} is formed as follows:
  - for each scratch digit, add 3 if the digit is ≥ 5 (all digits evaluated in parallel, combinationally);
  - shift {adjusted scratch, binary} left by 1; the binary MSB enters the scratch LSB;
  - increment the counter;
  - after iteration WIDTH (counter == WIDTH−1 on that edge), go to LATCH.
- **LATCH:** on the next edge:
  - `val_out` ← scratch, or all digits 4'h9 if `ovf`;
  - `overflow_out` ← `ovf`;
  - `valid_out` ← 1;
  - go to IDLE.
- `valid_out` is cleared on the following edge unless another LATCH occurs; back-to-back pulses are impossible given the latency.
- While not in IDLE, `valid_in` is ignored: no queueing, no error. `bin_in` changes after accept have no effect.
- `val_out` and `overflow_out` hold their values between results, so the display stays stable during a conversion.
- Scratch digits never exceed 9 after an adjust+shift for in-range inputs. For out-of-range inputs the scratch content is don't-care because the result is replaced by saturation.
- Width rule: the counter is $clog2(WIDTH+1) bits; the comparison with 10^DIGITS − 1 uses at least max(WIDTH, 34) bits so it does not truncate.

## Timing
- Reset (`rst_in` low, asynchronous): state = IDLE, `val_out` = 0, `valid_out` = 0, `overflow_out` = 0, counter and scratch = 0. `ready_out` reads 1 (IDLE), but no transfer occurs while `rst_in` is low.
- Reset asserted mid-conversion aborts it. No `valid_out` is produced for the aborted value and `val_out` returns to 0.
- Latency, with the accept edge as E0:
  - shifts occur on E1..E_WIDTH;
  - LATCH executes on E_(WIDTH+1);
  - `valid_out` and the new `val_out` are visible in the cycle after E_(WIDTH+1), i.e. 28 edges after accept at the default.
- `ready_out` is low from after E0 until after E_(WIDTH+1). It is high again in the same cycle as the `valid_out` pulse.
- Throughput: with `valid_in` held high, the next accept occurs at E_(WIDTH+2), giving one conversion per WIDTH+2 = 29 cycles.
- The downstream display controller samples `val_out` asynchronously to these events. Every `val_out` update must be a single-edge, all-bits-at-once register load, with no partial results ever visible.

## Test plan
- After reset release, drive `bin_in` = 0 with `valid_in` = 1 for one cycle. Required: `valid_out` pulses exactly 28 edges later; `val_out` = 32'h0000_0000; `overflow_out` = 0.
- Drive `bin_in` = 12,345,678. Required: `val_out` = 32'h1234_5678, `overflow_out` = 0, single-cycle `valid_out`, `ready_out` low for exactly the 28 edges after accept.
- Drive `bin_in` = 99,999,999, then 100,000,000, then 134,217,727. Required: `val_out` = 32'h9999_9999 each time, with `overflow_out` = 0, then 1, then 1.
- Accept 42, then pulse `valid_in` with `bin_in` = 7 at cycles 5 and 20 of the conversion. Required: the result is 32'h0000_0042 only, no second `valid_out`, and `val_out` holds its previous value until LATCH.
- Assert `rst_in` low asynchronously (mid-cycle) at cycle 10 of converting 555. Required: `val_out`, `valid_out` and `overflow_out` go to 0 immediately. After release, no `valid_out` appears and `ready_out` = 1; a new conversion of 9 yields 32'h0000_0009.
- Hold `valid_in` = 1 with `bin_in` stepping 1, 2, 3 at each accept. Required: accepts exactly 29 cycles apart; results 32'h1, 32'h2, 32'h3.
